// File: rtl/clk_div_detect.sv
// Measures high/low phase lengths of a divided clock, reports the period and locks on a stable ratio.
// Define DIV_SYNC_EN to pass div_clk through a 2-flop synchronizer for asynchronous sources.
module clk_div_detect #(
  parameter int CNT_W    = 4,
  parameter int LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_clk,
  output logic [CNT_W+1:0] ratio,
  output logic             ratio_valid,
  output logic             balanced,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ACQ, S_TRACK, S_LOCKED} state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);

  logic w_div;

`ifdef DIV_SYNC_EN
  logic [1:0] r_sync;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], div_clk};
  end
  assign w_div = r_sync[1];
`else
  assign w_div = div_clk;
`endif

  state_t             r_state, state_next;
  logic               r_div_d;
  logic [CNT_W-1:0]   r_half_cnt, half_next;
  logic [CNT_W:0]     r_high_len, high_next, r_low_len, low_next;
  logic [3:0]         r_match_cnt, match_next;
  logic               r_have_ratio, have_next;
  logic [CNT_W+1:0]   r_ratio, ratio_next;
  logic               r_ratio_valid, rv_next, r_balanced, bal_next;
  logic               r_locked, locked_next, r_timeout, timeout_next;

  logic               w_edge, w_rise, w_fall, w_half_max, w_match, w_do_ratio;
  logic [CNT_W:0]     w_len;
  logic [CNT_W+1:0]   w_new_ratio;
  logic [3:0]         w_match_inc;

  assign w_edge      = w_div ^ r_div_d;
  assign w_rise      = w_edge & w_div;
  assign w_fall      = w_edge & ~w_div;
  assign w_len       = {1'b0, r_half_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_new_ratio = {1'b0, r_high_len} + {1'b0, w_len};
  assign w_half_max  = &r_half_cnt;
  assign w_match     = r_have_ratio && (w_new_ratio == r_ratio);
  assign w_match_inc = r_match_cnt + 4'd1;

  always_comb begin
    state_next   = r_state;
    half_next    = r_half_cnt;
    high_next    = r_high_len;
    low_next     = r_low_len;
    match_next   = r_match_cnt;
    have_next    = r_have_ratio;
    ratio_next   = r_ratio;
    bal_next     = r_balanced;
    locked_next  = r_locked;
    rv_next      = 1'b0;
    timeout_next = 1'b0;
    w_do_ratio   = 1'b0;

    if (r_state != S_IDLE)
      half_next = w_edge ? '0 : r_half_cnt + 1'b1;

    case (r_state)
      S_IDLE: if (w_edge) state_next = S_SYNC;
      S_SYNC: if (w_edge) begin
        state_next = S_ACQ;
        if (w_rise) low_next  = w_len;
        else        high_next = w_len;
      end
      S_ACQ: if (w_edge) begin
        state_next = S_TRACK;
        if (w_fall) high_next = w_len;
        else begin
          low_next   = w_len;
          w_do_ratio = 1'b1;
        end
      end
      S_TRACK, S_LOCKED: begin
        if (w_fall) high_next = w_len;
        if (w_rise) begin
          low_next   = w_len;
          w_do_ratio = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // A completed period: publish it and advance or break the lock.
    if (w_do_ratio) begin
      ratio_next = w_new_ratio;
      bal_next   = (w_len == r_high_len);
      rv_next    = 1'b1;
      have_next  = 1'b1;
      if (!w_match) begin
        match_next  = '0;
        locked_next = 1'b0;
        state_next  = S_TRACK;
      end else if (r_state != S_LOCKED) begin
        match_next = w_match_inc;
        if (w_match_inc == LOCK_C) begin
          state_next  = S_LOCKED;
          locked_next = 1'b1;
        end
      end
    end

    if (r_state != S_IDLE && !w_edge && w_half_max) begin
      state_next   = S_IDLE;
      half_next    = '0;
      high_next    = '0;
      low_next     = '0;
      match_next   = '0;
      have_next    = 1'b0;
      locked_next  = 1'b0;
      timeout_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_div_d       <= 1'b1;
      r_half_cnt    <= '0;
      r_high_len    <= '0;
      r_low_len     <= '0;
      r_match_cnt   <= '0;
      r_have_ratio  <= 1'b0;
      r_ratio       <= '0;
      r_ratio_valid <= 1'b0;
      r_balanced    <= 1'b0;
      r_locked      <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= state_next;
      r_div_d       <= w_div;
      r_half_cnt    <= half_next;
      r_high_len    <= high_next;
      r_low_len     <= low_next;
      r_match_cnt   <= match_next;
      r_have_ratio  <= have_next;
      r_ratio       <= ratio_next;
      r_ratio_valid <= rv_next;
      r_balanced    <= bal_next;
      r_locked      <= locked_next;
      r_timeout     <= timeout_next;
    end
  end

  assign ratio       = r_ratio;
  assign ratio_valid = r_ratio_valid;
  assign balanced    = r_balanced;
  assign locked      = r_locked;
  assign timeout     = r_timeout;

endmodule
